instr_fetch_rv32i: RTL and testbench
====================================

Name: instr_fetch_rv32i

Overview:
Fetch-side initiator for the single-cycle RV32I core's instruction ROM (32x32, synchronous read, NOP on reset).
- Holds the fetch PC and drives the ROM byte address.
- Re-aligns the ROM's one-cycle read latency so each instruction is paired with its PC.
- Presents a valid instruction/PC pair to decode, with stall (hold) and redirect (branch/jump) support.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch byte address after reset (word aligned).
- NOP_INSTR, 32'h0000_0013, instruction shown when output is invalid (addi x0,x0,0).

Ports:
- clock  in  1  rising-edge clock shared with the ROM.
- reset  in  1  asynchronous, active-high reset.
- rom_addr  out  32  byte address to the ROM ADDR input; the ROM samples it on each rising edge.
- rom_instr  in  32  ROM INSTR output; returns the word at the rom_addr sampled on the previous edge.
- stall  in  1  decode cannot accept; hold the current output.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  target byte address; bits [1:0] are forced to 0.
- instr_out  out  32  instruction to decode.
- pc_out  out  32  byte address of instr_out.
- instr_valid  out  1  instr_out/pc_out hold a real, non-squashed instruction.

Behaviour:
- Internal registers:
  - fetch_pc: drives rom_addr directly.
  - pend_pc and pend_valid: the address the ROM sampled last edge, and whether it is live.
  - hold_instr: buffered instruction.
  - state: BOOT, RUN or HOLD.
- Reset (async, immediate):
  - state=BOOT; fetch_pc=RESET_PC; pend_pc=RESET_PC; pend_valid=0; hold_instr=NOP_INSTR.
  - Outputs: rom_addr=RESET_PC, instr_out=NOP_INSTR, pc_out=RESET_PC, instr_valid=0.
- Output mux:
  - RUN: instr_out = pend_valid ? rom_instr : NOP_INSTR; pc_out=pend_pc; instr_valid=pend_valid.
  - HOLD: instr_out=hold_instr; pc_out=pend_pc; instr_valid=1.
  - BOOT: as in reset.
- BOOT: the first edge after reset deasserts moves pend_pc<=RESET_PC, pend_valid<=1, fetch_pc<=RESET_PC+4 and goes to RUN. The first valid instruction is visible one edge after reset release.
- RUN, no stall, no redirect, each edge: pend_pc<=fetch_pc; pend_valid<=1; fetch_pc<=fetch_pc+4. Throughput is one instruction per cycle.
- RUN with stall=1 and instr_valid=1, at the edge:
  - hold_instr<=rom_instr; state<=HOLD.
  - fetch_pc and pend_pc unchanged.
  - The ROM keeps re-reading fetch_pc.
- RUN with stall=1 and instr_valid=0: stall is ignored (nothing to hold) and the pipeline advances normally.
- HOLD with stall=1: all registers unchanged; output stable for any number of cycles.
- HOLD with stall=0, at the edge:
  - pend_pc<=fetch_pc; fetch_pc<=fetch_pc+4; state<=RUN.
  - rom_instr then equals mem[old fetch_pc], so there is no bubble and no duplicate.
- Redirect (any state except BOOT; priority over stall), at the edge:
  - fetch_pc<=redirect_pc & ~3; pend_valid<=0; state<=RUN.
  - The word the ROM sampled at that edge (wrong path) is squashed.
  - Next edge: pend_pc<=target, pend_valid<=1.
  - Penalty is exactly one bubble cycle (instr_valid=0).
- Redirect while stall=1 in HOLD: the held instruction is discarded; redirect wins.
- Arithmetic: 32-bit PC increment wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
- Reset mid-stall or mid-redirect: returns to BOOT and the held instruction is lost.

Test Plan:
- Bench ROM model has one-cycle latency and is loaded with word0=0x00100293, word1=0x00000333, word2=0x00B00393, word3=0x00530333.
- Reset then release, no stall: edge1 gives valid=1, pc=0, instr=0x00100293; edge2 gives pc=4, instr=0x00000333; edge3 gives pc=8, instr=0x00B00393. rom_addr reads 0, 4, 8, 12 one cycle ahead.
- Stall raised while pc_out=4 and held 3 cycles: instr_out=0x00000333, pc_out=4, valid=1 throughout. After release, the next cycle is pc=8, instr=0x00B00393; no skipped or repeated PC.
- redirect=1, redirect_pc=0x0000000E while pc_out=8: next cycle valid=0 and instr_out=0x00000013. The following cycle gives pc=0x0C, instr=0x00530333.
- Redirect and stall asserted together in HOLD, target 0: one bubble, then pc=0, instr=0x00100293; the held word is dropped.
- Redirect to 0xFFFFFFFC (ROM aliasing returns word31=NOP): pc_out=0xFFFFFFFC, then 0x00000000 with instr 0x00100293. Reset asserted mid-HOLD immediately shows valid=0, instr=NOP, rom_addr=0.

Source files
------------

// File: rtl/instr_fetch_rv32i_if.sv
// rtl/instr_fetch_rv32i_if.sv - ROM fetch and decode-side signal bundle for instr_fetch_rv32i
interface instr_fetch_rv32i_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    modport master (
        output rom_addr,
        input  rom_instr,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output instr_out,
        output pc_out,
        output instr_valid
    );

    modport slave (
        input  rom_addr,
        output rom_instr,
        output stall,
        output redirect,
        output redirect_pc,
        input  instr_out,
        input  pc_out,
        input  instr_valid
    );
endinterface

// File: rtl/instr_fetch_rv32i.sv
// rtl/instr_fetch_rv32i.sv - RV32I fetch stage pairing a one-cycle-latency ROM word with its PC
module instr_fetch_rv32i #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clock,
    input  logic                 reset,
    instr_fetch_rv32i_if.master  bus
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] fetch_pc_inc;
    logic [31:0] redirect_target;

    assign fetch_pc_inc    = fetch_pc + 32'd4;
    assign redirect_target = bus.redirect_pc & ~32'd3;
    assign bus.rom_addr    = fetch_pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            pend_pc    <= RESET_PC;
            pend_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            pend_pc    <= pend_pc_nxt;
            pend_valid <= pend_valid_nxt;
            hold_instr <= hold_instr_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        pend_pc_nxt     = pend_pc;
        pend_valid_nxt  = pend_valid;
        hold_instr_nxt  = hold_instr;
        bus.instr_out   = NOP_INSTR;
        bus.pc_out      = RESET_PC;
        bus.instr_valid = 1'b0;

        unique case (state)
            BOOT: begin
                pend_pc_nxt    = RESET_PC;
                pend_valid_nxt = 1'b1;
                fetch_pc_nxt   = RESET_PC + 32'd4;
                state_nxt      = RUN;
            end

            RUN: begin
                bus.instr_out   = pend_valid ? bus.rom_instr : NOP_INSTR;
                bus.pc_out      = pend_pc;
                bus.instr_valid = pend_valid;
                if (bus.redirect) begin
                    // The word the ROM samples at this edge is wrong-path; drop it.
                    fetch_pc_nxt   = redirect_target;
                    pend_valid_nxt = 1'b0;
                end else if (bus.stall && pend_valid) begin
                    hold_instr_nxt = bus.rom_instr;
                    state_nxt      = HOLD;
                end else begin
                    pend_pc_nxt    = fetch_pc;
                    pend_valid_nxt = 1'b1;
                    fetch_pc_nxt   = fetch_pc_inc;
                end
            end

            HOLD: begin
                bus.instr_out   = hold_instr;
                bus.pc_out      = pend_pc;
                bus.instr_valid = 1'b1;
                if (bus.redirect) begin
                    fetch_pc_nxt   = redirect_target;
                    pend_valid_nxt = 1'b0;
                    state_nxt      = RUN;
                end else if (!bus.stall) begin
                    // ROM kept re-reading fetch_pc while held, so its output is already that word.
                    pend_pc_nxt  = fetch_pc;
                    fetch_pc_nxt = fetch_pc_inc;
                    state_nxt    = RUN;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_rv32i.sv
// tb/tb_instr_fetch_rv32i.sv - self-checking bench for instr_fetch_rv32i
module tb_instr_fetch_rv32i;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset = 1'b1;
    instr_fetch_rv32i_if bus();

    instr_fetch_rv32i dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    logic [31:0] mem [32];

    always @(posedge clock or posedge reset) begin
        if (reset) bus.rom_instr <= NOP;
        else       bus.rom_instr <= mem[bus.rom_addr[6:2]];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return mem[addr[6:2]];
    endfunction

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt [15];

    logic        m_valid, m_boot;
    logic [31:0] m_pc, m_instr, m_next;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0]  = 32'h0010_0293;
        mem[1]  = 32'h0000_0333;
        mem[2]  = 32'h00B0_0393;
        mem[3]  = 32'h0053_0333;
        mem[31] = NOP;

        vt[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,        32'h0010_0293, 32'h4};
        vt[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4,        32'h0000_0333, 32'h8};
        vt[2]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4,        32'h0000_0333, 32'h8};
        vt[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4,        32'h0000_0333, 32'h8};
        vt[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4,        32'h0000_0333, 32'h8};
        vt[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8,        32'h00B0_0393, 32'hC};
        vt[6]  = '{1'b0, 1'b1, 32'hE, 1'b0, 32'h0,        NOP,           32'hC};
        vt[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC,        32'h0053_0333, 32'h10};
        vt[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hC,        32'h0053_0333, 32'h10};
        vt[9]  = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0,        NOP,           32'h0};
        vt[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,        32'h0010_0293, 32'h4};
        vt[11] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, NOP,          32'hFFFF_FFFC};
        vt[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, NOP,          32'h0};
        vt[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,        32'h0010_0293, 32'h4};
        vt[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0,        32'h0010_0293, 32'h4};

        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("reset_instr", bus.instr_out, NOP);
        chk("reset_pc", bus.pc_out, 32'h0);
        chk("reset_addr", bus.rom_addr, 32'h0);

        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.stall       = vt[i].stall;
            bus.redirect    = vt[i].redirect;
            bus.redirect_pc = vt[i].tgt;
            @(posedge clock);
            #1;
            chk($sformatf("dir%0d_valid", i), {31'b0, bus.instr_valid}, {31'b0, vt[i].ev});
            chk($sformatf("dir%0d_instr", i), bus.instr_out, vt[i].einstr);
            chk($sformatf("dir%0d_addr", i), bus.rom_addr, vt[i].eaddr);
            if (vt[i].ev) chk($sformatf("dir%0d_pc", i), bus.pc_out, vt[i].epc);
            @(negedge clock);
        end

        reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("async_reset_instr", bus.instr_out, NOP);
        chk("async_reset_addr", bus.rom_addr, 32'h0);

        m_valid = 1'b0; m_boot = 1'b1; m_pc = 32'h0; m_instr = NOP; m_next = 32'h0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            reset           = ($urandom_range(0, 63) == 0);
            bus.stall       = ($urandom_range(0, 2) == 0);
            bus.redirect    = ($urandom_range(0, 7) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 127);
            @(posedge clock);
            #1;
            if (reset) begin
                m_valid = 1'b0; m_boot = 1'b1; m_pc = 32'h0; m_instr = NOP; m_next = 32'h0;
            end else if (m_boot) begin
                m_boot = 1'b0; m_valid = 1'b1; m_pc = 32'h0; m_instr = rom_word(32'h0); m_next = 32'h4;
            end else if (bus.redirect) begin
                m_valid = 1'b0; m_instr = NOP; m_next = bus.redirect_pc & ~32'd3;
            end else if (bus.stall && m_valid) begin
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b1; m_pc = m_next; m_instr = rom_word(m_next); m_next = m_next + 32'd4;
            end
            chk("rnd_valid", {31'b0, bus.instr_valid}, {31'b0, m_valid});
            chk("rnd_instr", bus.instr_out, m_instr);
            chk("rnd_addr", bus.rom_addr, m_next);
            if (m_valid || reset) chk("rnd_pc", bus.pc_out, m_pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
